multiply: RTL and testbench

MULTIPLY -- requirements
Module: multiply

---
 rtl/multiply.sv | 79 +++++++
 tb/tb_multiply.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiply.sv
// Two-stage signed multiplier with elastic handshake and vector framing tags
// (clr on the first element, lst on the last) for a downstream accumulator.
module multiply #(
  parameter int ARGW = 16,
  parameter int RESW = 32,
  parameter int LEN  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            arg_stb,
  input  logic [ARGW-1:0] arg_dat_a,
  input  logic [ARGW-1:0] arg_dat_b,
  output logic            arg_rdy,
  output logic            res_stb,
  output logic [RESW-1:0] res_dat,
  output logic            res_clr,
  output logic            res_lst,
  input  logic            res_rdy
);

  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(LEN - 1);

  if (RESW < 2 * ARGW || LEN < 1) begin : g_bad_params
    $error("multiply: need RESW >= 2*ARGW and LEN >= 1");
  end

  logic [2:1]             vld_pipe;
  logic                   adv;
  logic                   acc;
  logic [IW-1:0]          idx;
  logic signed [ARGW-1:0] a1, b1;
  logic                   clr1, lst1;
  logic signed [RESW-1:0] prod;

  // S2 drains when empty or consumed; S1 can take a new pair whenever it
  // is empty or moving into S2 this cycle.
  assign adv     = ~vld_pipe[2] | res_rdy;
  assign arg_rdy = ~vld_pipe[1] | adv;
  assign acc     = arg_stb & arg_rdy;
  assign res_stb = vld_pipe[2];

  // Operands are sign-extended before the multiply so the product is exact.
  assign prod = RESW'(a1) * RESW'(b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      idx      <= '0;
      a1       <= '0;
      b1       <= '0;
      clr1     <= 1'b0;
      lst1     <= 1'b0;
      res_dat  <= '0;
      res_clr  <= 1'b0;
      res_lst  <= 1'b0;
    end else begin
      if (arg_rdy) begin
        vld_pipe[1] <= acc;
        if (acc) begin
          a1   <= arg_dat_a;
          b1   <= arg_dat_b;
          clr1 <= (idx == '0);
          lst1 <= (idx == IDX_LAST);
          idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      if (adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          res_dat <= prod;
          res_clr <= clr1;
          res_lst <= lst1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiply.sv
// Bench for multiply: three instances (LEN 4, 1, 8) share stimulus; a queue
// model of accepted pairs checks every delivered product and its framing.
`timescale 1ns/1ps
module tb_multiply;
  localparam int ARGW = 16;
  localparam int RESW = 32;
  localparam int NI   = 3;

  typedef struct {
    logic signed [RESW-1:0] p;
    int                     n;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            arg_stb = 1'b0;
  logic [ARGW-1:0] arg_dat_a = '0;
  logic [ARGW-1:0] arg_dat_b = '0;
  logic            res_rdy = 1'b1;

  logic            ardy [NI];
  logic            rstb [NI];
  logic [RESW-1:0] rdat [NI];
  logic            rclr [NI];
  logic            rlst [NI];

  int   lens [NI] = '{4, 1, 8};
  exp_t q [NI][$];
  int   nacc   = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multiply #(.ARGW(ARGW), .RESW(RESW), .LEN(4)) u4 (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat_a(arg_dat_a), .arg_dat_b(arg_dat_b),
    .arg_rdy(ardy[0]), .res_stb(rstb[0]), .res_dat(rdat[0]), .res_clr(rclr[0]),
    .res_lst(rlst[0]), .res_rdy(res_rdy));
  multiply #(.ARGW(ARGW), .RESW(RESW), .LEN(1)) u1 (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat_a(arg_dat_a), .arg_dat_b(arg_dat_b),
    .arg_rdy(ardy[1]), .res_stb(rstb[1]), .res_dat(rdat[1]), .res_clr(rclr[1]),
    .res_lst(rlst[1]), .res_rdy(res_rdy));
  multiply #(.ARGW(ARGW), .RESW(RESW), .LEN(8)) u8 (
    .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat_a(arg_dat_a), .arg_dat_b(arg_dat_b),
    .arg_rdy(ardy[2]), .res_stb(rstb[2]), .res_dat(rdat[2]), .res_clr(rclr[2]),
    .res_lst(rlst[2]), .res_rdy(res_rdy));

  // Scoreboard: sampled mid-cycle, inputs are driven just after posedge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < NI; i++) q[i].delete();
      nacc = 0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (rstb[i] && res_rdy) begin
          checks++;
          if (q[i].size() == 0) begin
            errors++;
            $display("FAIL sb_extra inst%0d: got product %0d, required none", i, $signed(rdat[i]));
          end else begin
            e = q[i].pop_front();
            if (rdat[i] !== e.p) begin
              errors++;
              $display("FAIL sb_dat inst%0d elem %0d: got %0d, required %0d", i, e.n, $signed(rdat[i]), e.p);
            end
            checks++;
            if (rclr[i] !== (e.n % lens[i] == 0)) begin
              errors++;
              $display("FAIL sb_clr inst%0d elem %0d: got %b, required %b", i, e.n, rclr[i], (e.n % lens[i] == 0));
            end
            checks++;
            if (rlst[i] !== (e.n % lens[i] == lens[i] - 1)) begin
              errors++;
              $display("FAIL sb_lst inst%0d elem %0d: got %b, required %b", i, e.n, rlst[i], (e.n % lens[i] == lens[i] - 1));
            end
          end
        end
      end
      if (arg_stb && ardy[0]) begin
        e.p = RESW'(longint'($signed(arg_dat_a)) * longint'($signed(arg_dat_b)));
        e.n = nacc;
        for (int i = 0; i < NI; i++) q[i].push_back(e);
        nacc++;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; arg_stb = 1'b0; res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    arg_stb = 1'b0; res_rdy = 1'b1;
    for (int c = 0; c < 20 && (q[0].size() + q[1].size() + q[2].size()) != 0; c++) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; arg_stb = 1'b1; arg_dat_a = 16'd5; arg_dat_b = 16'd6; res_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (rstb[i] !== 1'b0 || rdat[i] !== '0 || rclr[i] !== 1'b0 || rlst[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got stb=%b dat=%0d clr=%b lst=%b, required all 0",
                 i, rstb[i], rdat[i], rclr[i], rlst[i]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; arg_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (ardy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_arg_rdy: got %b, required 1", ardy[0]);
    end
  endtask

  task automatic test_free_flow();
    int pa [4] = '{3, -2, 7, 1};
    int pb [4] = '{4, 5, -7, 1};
    int ea [4] = '{12, -10, -49, 1};
    do_reset();
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      if (t < 4) begin
        arg_stb = 1'b1; arg_dat_a = 16'(pa[t]); arg_dat_b = 16'(pb[t]);
      end else arg_stb = 1'b0;
      @(negedge clk);
      checks++;
      if (rstb[0] !== (t >= 2)) begin
        errors++;
        $display("FAIL flow_latency t=%0d: got res_stb=%b, required %b", t, rstb[0], (t >= 2));
      end
      if (t >= 2) begin
        checks++;
        if (rdat[0] !== 32'(ea[t-2]) || rclr[0] !== (t == 2) || rlst[0] !== (t == 5)) begin
          errors++;
          $display("FAIL flow_elem%0d: got dat=%0d clr=%b lst=%b, required dat=%0d clr=%b lst=%b",
                   t - 2, $signed(rdat[0]), rclr[0], rlst[0], ea[t-2], (t == 2), (t == 5));
        end
      end
    end
    drain();
  endtask

  task automatic test_extremes();
    int     pa [3] = '{-32768, -32768, 0};
    int     pb [3] = '{-32768, 32767, 0};
    longint ea [3] = '{64'sd1073741824, -64'sd1073709056, 64'sd0};
    pb[2] = int'($urandom_range(0, 65535)) - 32768;
    do_reset();
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      if (t < 3) begin
        arg_stb = 1'b1; arg_dat_a = 16'(pa[t]); arg_dat_b = 16'(pb[t]);
      end else arg_stb = 1'b0;
      @(negedge clk);
      if (t >= 2) begin
        checks++;
        if (rstb[0] !== 1'b1 || rdat[0] !== 32'(ea[t-2])) begin
          errors++;
          $display("FAIL extreme%0d: got stb=%b dat=%0d, required stb=1 dat=%0d",
                   t - 2, rstb[0], $signed(rdat[0]), ea[t-2]);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int              k = 0;
    bit              seen = 1'b0;
    logic [RESW-1:0] held = '0;
    logic            hclr = 1'b0, hlst = 1'b0;
    do_reset();
    res_rdy = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        arg_stb = 1'b1; arg_dat_a = 16'(100 + k); arg_dat_b = 16'(-3 - k);
      end else arg_stb = 1'b0;
      @(negedge clk);
      if (rstb[0]) begin
        if (!seen) begin
          seen = 1'b1; held = rdat[0]; hclr = rclr[0]; hlst = rlst[0];
          checks++;
          if (rdat[0] !== 32'(-300) || rclr[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got dat=%0d clr=%b, required dat=-300 clr=1", $signed(rdat[0]), rclr[0]);
          end
        end else begin
          checks++;
          if (rdat[0] !== held || rclr[0] !== hclr || rlst[0] !== hlst) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d: got dat=%0d clr=%b lst=%b, required dat=%0d clr=%b lst=%b",
                     cyc, $signed(rdat[0]), rclr[0], rlst[0], $signed(held), hclr, hlst);
          end
        end
      end
      if (arg_stb && ardy[0]) k++;
    end
    checks++;
    if (k != 2 || ardy[0] !== 1'b0 || !seen) begin
      errors++;
      $display("FAIL bp_stall: got accepted=%0d arg_rdy=%b seen=%b, required accepted=2 arg_rdy=0 seen=1",
               k, ardy[0], seen);
    end
    @(posedge clk); #1;
    res_rdy = 1'b1;
    for (int c = 0; c < 10 && k < 3; c++) begin
      arg_stb = 1'b1; arg_dat_a = 16'(100 + k); arg_dat_b = 16'(-3 - k);
      @(negedge clk);
      if (arg_stb && ardy[0]) k++;
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (k != 3 || (q[0].size() + q[1].size() + q[2].size()) != 0) begin
      errors++;
      $display("FAIL bp_delivery: got accepted=%0d pending=%0d, required accepted=3 pending=0", k, q[0].size());
    end
  endtask

  task automatic test_wrap();
    logic [8:0] clrm = '0, lstm = '0;
    int o = 0;
    do_reset();
    for (int t = 0; t < 11; t++) begin
      @(posedge clk); #1;
      if (t < 9) begin
        arg_stb = 1'b1; arg_dat_a = 16'($urandom); arg_dat_b = 16'($urandom);
      end else arg_stb = 1'b0;
      @(negedge clk);
      if (rstb[0] && res_rdy && o < 9) begin
        clrm[o] = rclr[0]; lstm[o] = rlst[0]; o++;
      end
    end
    checks++;
    if (o != 9 || clrm !== 9'b1_0001_0001 || lstm !== 9'b0_1000_1000) begin
      errors++;
      $display("FAIL wrap_tags: got n=%0d clr=%b lst=%b, required n=9 clr=100010001 lst=010001000", o, clrm, lstm);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      arg_stb = 1'b1; arg_dat_a = 16'(t + 2); arg_dat_b = 16'(t + 3);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; arg_stb = 1'b0;
    @(negedge clk);
    checks++;
    if (rstb[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stb: got %b, required 0", rstb[0]);
    end
    @(posedge clk); #1;
    arg_stb = 1'b1; arg_dat_a = 16'd9; arg_dat_b = 16'd9;
    @(posedge clk); #1;
    arg_stb = 1'b0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      if (rstb[0]) begin
        found = 1'b1;
        checks++;
        if (rclr[0] !== 1'b1 || rdat[0] !== 32'd81) begin
          errors++;
          $display("FAIL midreset_first: got clr=%b dat=%0d, required clr=1 dat=81", rclr[0], $signed(rdat[0]));
        end
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL midreset_timeout: got no product, required one within 5 cycles");
    end
    drain();
  endtask

  task automatic test_random();
    int cnt = 0;
    int cyc = 0;
    do_reset();
    while (cnt < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      arg_stb = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) begin
        arg_dat_a = 16'h8000; arg_dat_b = $urandom_range(0, 1) ? 16'h8000 : 16'h7fff;
      end else begin
        arg_dat_a = 16'($urandom); arg_dat_b = 16'($urandom);
      end
      res_rdy = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (arg_stb && ardy[0]) cnt++;
      cyc++;
    end
    drain();
    checks++;
    if (cnt != 10000 || (q[0].size() + q[1].size() + q[2].size()) != 0) begin
      errors++;
      $display("FAIL random_run: got accepted=%0d pending=%0d, required accepted=10000 pending=0", cnt, q[0].size());
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_flow();
    test_extremes();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
